// File: rtl/tag_arb_pkg.sv
// Shared constants and types for the tag arbiter slice.
//   DEF_NUM_REQ / DEF_TAG_W / DEF_CNT_W : default requester count, tag width, counter width
//   tag_t     : one tag as exchanged with pmem_group
//   req_idx_t : requester index at the default requester count
package tag_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_TAG_W   = 10;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef logic [DEF_TAG_W-1:0]            tag_t;
  typedef logic [$clog2(DEF_NUM_REQ)-1:0]  req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req    : request vector
//   last   : index granted most recently; search starts at last+1
//   any    : at least one request present
//   winner : index of the first request found scanning last+1, last+2, ... mod NUM_REQ
//   grant  : one-hot form of winner (all-0 when no request)
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // First hit at the smallest rotation offset wins; offset NUM_REQ revisits last itself.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    any    = 1'b0;
    winner = '0;
    grant  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last) + off) % NUM_REQ;
      if (!any && req[IDX_W'(idx)]) begin
        any    = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    if (any) begin
      grant = NUM_REQ'(1) << winner;
    end
  end

endmodule

// File: rtl/tag_arbiter.sv
// Round-robin merge of NUM_REQ tag-request streams into the pmem_group tagin stream.
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   req_data/req_valid : per-requester tag offers (flattened, requester i at slice i)
//   req_ready          : combinational accept, one-hot on the winning requester
//   tagin_*            : registered output stage towards pmem_group
//   enable             : 0 blocks new grants; a held tag still drains
//   clear_counts       : synchronous clear of all issue counters
//   grant_id           : requester that supplied the tag in the output register
//   issue_count        : saturating per-requester accept counters (flattened)
module tag_arbiter
  import tag_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ*TAG_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [TAG_W-1:0]             tagin_data,
  output logic                         tagin_valid,
  input  logic                         tagin_ready,
  input  logic                         enable,
  input  logic                         clear_counts,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [NUM_REQ*CNT_W-1:0]     issue_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     last_q;
  logic                 load_c;
  logic [TAG_W-1:0]     win_data_c;
  logic [CNT_W-1:0]     cnt_q [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_idx),
    .grant  (pick_grant)
  );

  // Output slot is free or emptying this cycle; reset term keeps req_ready low during reset.
  assign load_c    = reset & enable & pick_any & (~tagin_valid | tagin_ready);
  assign req_ready = load_c ? pick_grant : '0;

  // One-hot AND-OR mux of the winning requester's tag.
  always_comb begin
    win_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        win_data_c = win_data_c | req_data[i*TAG_W +: TAG_W];
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tagin_valid <= 1'b0;
      tagin_data  <= '0;
      grant_id    <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
    end else if (load_c) begin
      tagin_valid <= 1'b1;
      tagin_data  <= win_data_c;
      grant_id    <= pick_idx;
      last_q      <= pick_idx;
    end else if (tagin_ready) begin
      tagin_valid <= 1'b0;
    end
  end

  // Saturating issue counters; clear takes priority over a same-cycle accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (clear_counts) begin
          cnt_q[i] <= '0;
        end else if (load_c && pick_grant[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    issue_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      issue_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule
